// File: rtl/fib_arbiter_if.sv
// Requester and fib-unit signal bundle for fib_arbiter.
//   slave  : arbiter side (takes req/req_n and fib_done/result/overflow,
//            drives ack, rsp_*, busy, fib_go, fib_n)
//   master : requester/fib-unit side (the opposite directions)
interface fib_arbiter_if #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned INPUT_WIDTH  = 6,
  parameter int unsigned OUTPUT_WIDTH = 32
);
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*INPUT_WIDTH-1:0] req_n;
  logic [NUM_REQ-1:0]             ack;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [OUTPUT_WIDTH-1:0]        rsp_result;
  logic                           rsp_overflow;
  logic                           rsp_error;
  logic                           busy;
  logic                           fib_go;
  logic [INPUT_WIDTH-1:0]         fib_n;
  logic                           fib_done;
  logic [OUTPUT_WIDTH-1:0]        fib_result;
  logic                           fib_overflow;

  modport slave (
    input  req, req_n, fib_done, fib_result, fib_overflow,
    output ack, rsp_valid, rsp_result, rsp_overflow, rsp_error, busy, fib_go, fib_n
  );

  modport master (
    output req, req_n, fib_done, fib_result, fib_overflow,
    input  ack, rsp_valid, rsp_result, rsp_overflow, rsp_error, busy, fib_go, fib_n
  );
endinterface

// File: rtl/fib_arbiter.sv
// Round-robin sharing of one fib unit between NUM_REQ requesters, with a
// go/done sequencer and a watchdog that answers with an error response.
//   clk_i  : clock, posedge
//   rst_ni : asynchronous active-low reset
//   bus    : fib_arbiter_if.slave (requests, responses, fib-unit handshake)
// All outputs are registered.
module fib_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned INPUT_WIDTH    = 6,
  parameter int unsigned OUTPUT_WIDTH   = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  fib_arbiter_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_CLR  = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        win_q, win_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [OUTPUT_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                    rsp_ovf_q, rsp_ovf_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    busy_q, busy_d;
  logic                    go_q, go_d;
  logic [INPUT_WIDTH-1:0]  fib_n_q, fib_n_d;

  logic                    found_c;
  logic [IDX_W-1:0]        pick_c;
  logic [IDX_W-1:0]        idx_c;
  logic [INPUT_WIDTH-1:0]  operand_c;

  // Round-robin pick: first set req bit scanning upward from the pointer.
  always_comb begin
    found_c = 1'b0;
    pick_c  = '0;
    idx_c   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx_c = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!found_c && bus.req[idx_c]) begin
        found_c = 1'b1;
        pick_c  = idx_c;
      end
    end
  end

  // Operand slice of the picked requester (constant-base selects only).
  always_comb begin
    operand_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (32'(pick_c) == i) begin
        operand_c = bus.req_n[i*INPUT_WIDTH +: INPUT_WIDTH];
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
    cnt_d        = cnt_q;
    ack_d        = '0;
    rsp_valid_d  = '0;
    go_d         = 1'b0;
    fib_n_d      = fib_n_q;
    rsp_result_d = rsp_result_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_err_d    = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (found_c) begin
          ack_d   = NUM_REQ'(1) << pick_c;
          go_d    = 1'b1;
          fib_n_d = operand_c;
          win_d   = pick_c;
          ptr_d   = IDX_W'((32'(pick_c) + 32'd1) % NUM_REQ);
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        state_d = WAIT_CLR;
      end
      WAIT_CLR: begin
        // A done left high by the previous job must fall before we trust it.
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == TMO_LAST) begin
          rsp_valid_d  = NUM_REQ'(1) << win_q;
          rsp_result_d = '0;
          rsp_ovf_d    = 1'b0;
          rsp_err_d    = 1'b1;
          state_d      = RESP;
        end else if (!bus.fib_done) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // A completion on the timeout cycle wins over the error response.
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.fib_done) begin
          rsp_valid_d  = NUM_REQ'(1) << win_q;
          rsp_result_d = bus.fib_result;
          rsp_ovf_d    = bus.fib_overflow;
          rsp_err_d    = 1'b0;
          state_d      = RESP;
        end else if (cnt_q == TMO_LAST) begin
          rsp_valid_d  = NUM_REQ'(1) << win_q;
          rsp_result_d = '0;
          rsp_ovf_d    = 1'b0;
          rsp_err_d    = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      win_q        <= '0;
      cnt_q        <= '0;
      ack_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      go_q         <= 1'b0;
      fib_n_q      <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
      go_q         <= go_d;
      fib_n_q      <= fib_n_d;
    end
  end

  assign bus.ack          = ack_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_overflow = rsp_ovf_q;
  assign bus.rsp_error    = rsp_err_q;
  assign bus.busy         = busy_q;
  assign bus.fib_go       = go_q;
  assign bus.fib_n        = fib_n_q;
endmodule

// File: doc/fib_arbiter.md
Name: fib_arbiter

Overview:
- Shares one fib datapath unit between NUM_REQ independent requesters using round-robin arbitration.
- Sequences the unit's go/done handshake and routes the captured result/overflow back to the winning requester.
- Includes a watchdog so a hung unit cannot stall every requester.
- Sits between requester logic and a single fib instance; the fib instance keeps its own reset.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
INPUT_WIDTH, 6, width of each n operand
OUTPUT_WIDTH, 32, width of result
TIMEOUT_CYCLES, 1024, max cycles from go to done before an error response

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester request level; held with req_n until ack
req_n  in  NUM_REQ*INPUT_WIDTH  packed operands; requester i uses bits [i*INPUT_WIDTH +: INPUT_WIDTH]
ack  out  NUM_REQ  one-hot, 1-cycle pulse: request accepted
rsp_valid  out  NUM_REQ  one-hot, 1-cycle pulse: response for that requester
rsp_result  out  OUTPUT_WIDTH  result; valid while rsp_valid is nonzero, held until the next response
rsp_overflow  out  1  overflow flag; same timing as rsp_result
rsp_error  out  1  1 = watchdog timeout; same timing as rsp_result
busy  out  1  1 whenever state is not IDLE
fib_go  out  1  go to the fib unit
fib_n  out  INPUT_WIDTH  n to the fib unit; held from go until done
fib_done  in  1  done from the fib unit
fib_result  in  OUTPUT_WIDTH  result from the fib unit
fib_overflow  in  1  overflow from the fib unit

Behaviour:
- Reset (rst=0, async): state=IDLE; rr pointer=0; all outputs 0, including fib_n, rsp_result, rsp_overflow and rsp_error. Reset mid-operation abandons the job; no rsp_valid is ever issued for it.
- All outputs are registered.
- States and transitions:
  - IDLE: if any req bit is set, pick the winner w = first set bit scanning from pointer upward, wrapping modulo NUM_REQ. Next cycle: ack[w]=1, fib_go=1, fib_n=req_n slice of w. Latch w. Pointer=(w+1)%NUM_REQ. Go to START. No req: stay in IDLE.
  - START: exactly one cycle with fib_go=1, then fib_go=0. Go to WAIT_CLR.
  - WAIT_CLR: wait for fib_done=0. This covers a stale done=1 left by the previous job, which the unit clears the cycle after go. Then go to WAIT_DONE.
  - WAIT_DONE: on fib_done=1, capture fib_result and fib_overflow; rsp_error=0. Go to RESP.
  - RESP: rsp_valid[w]=1 for one cycle. Go to IDLE.
- Arbitration happens only in IDLE.
- Latency: req sampled at edge k → ack/go high after edge k+1 → earliest next grant is the cycle after RESP.
- Watchdog:
  - Counter clears on entry to START and increments in WAIT_CLR and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES: go to RESP with rsp_result=0, rsp_overflow=0, rsp_error=1.
  - After a timeout, WAIT_CLR still guards the next job.
- fib_n stays stable from go until leaving WAIT_DONE, or until timeout.
- Requester rules:
  - A requester may drop req the cycle after its ack.
  - A req deasserted before ack is simply not served.
  - A requester may re-assert req in the same cycle as its rsp_valid; it is eligible in the following IDLE.
  - Multiple req bits set simultaneously: exactly one ack, chosen by the pointer. The others stay pending with no ack.
- Fairness: with all requesters continuously requesting, grants cycle 0,1,..,NUM_REQ-1,0,…
- Done without go: fib_done rising while in IDLE, START, WAIT_CLR or RESP is ignored. fib_done is only sampled as completion in WAIT_DONE.
- Invariants: ack and rsp_valid each have at most one bit set (one-hot or zero). fib_go is never high for two consecutive cycles.

Test Plan:
- Reset then req[0]=1 with n=10 → ack[0] pulse with fib_go pulse the next cycle; later rsp_valid[0]=1 with rsp_result=55, overflow=0, error=0; busy returns to 0.
- req[2]=1 with n=48 → rsp_valid[2], rsp_overflow=1.
- req=4'b1111 held; n_i = 5, 6, 7, 8 for requesters 0–3 → responses in order 0,1,2,3 with results 5, 8, 13, 21; each requester drops req after its ack; exactly one ack per grant.
- Fib model that never raises done, TIMEOUT_CYCLES=16 → rsp_valid[w] exactly 16 cycles after entering WAIT_CLR, rsp_error=1, rsp_result=0; a following req is then served normally.
- Two jobs back-to-back where the unit's done is still 1 from the first job → second response waits for done to fall and then rise; result matches the second n.
- Assert rst=0 during WAIT_DONE → all outputs 0 immediately; no rsp_valid for the abandoned job; pointer=0, so req=4'b0110 is granted to requester 1.
